// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcodes, controller states and result flags.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic err;
    } flag_t;

endpackage

// File: rtl/alu_exec.sv
// Combinational execute stage for every opcode except MUL, which the sequencer iterates.
module alu_exec
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  op_t          op,
    output logic [N-1:0] result,
    output flag_t        flags
);

    localparam int SW  = $clog2(N);
    // Wide enough to hold a shifted by the largest encodable amount, so no bit is lost.
    localparam int SHW = N + (1 << SW);

    logic [N:0]     sum_s;
    logic [N:0]     diff_s;
    logic [SW-1:0]  sh_s;
    logic [SHW-1:0] shl_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};
    assign sh_s   = b[SW-1:0];
    assign shl_s  = {{(SHW-N){1'b0}}, a} << sh_s;

    // Opcode decode into result and flags; zero always follows the final result.
    always_comb begin
        result = '0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                result      = sum_s[N-1:0];
                flags.carry = sum_s[N];
            end
            OP_SUB: begin
                result      = diff_s[N-1:0];
                flags.carry = diff_s[N];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL: begin
                result      = shl_s[N-1:0];
                flags.carry = |shl_s[SHW-1:N];
            end
            OP_RSVD: flags.err = 1'b1;
            default: result = '0;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer: accepts one op, runs it (MUL as N shift-add steps) and holds the result until taken.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         err
);

    localparam int CW = $clog2(N);

    state_t           state_r;
    state_t           next_state_s;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    op_t              op_r;
    logic [2*N-1:0]   mcand_r;
    logic [N-1:0]     mplier_r;
    logic [2*N-1:0]   acc_r;
    logic [2*N-1:0]   addend_s;
    logic [2*N-1:0]   acc_step_s;
    logic [CW-1:0]    cnt_r;
    logic [N-1:0]     result_r;
    flag_t            flags_r;
    logic             out_valid_r;
    logic [N-1:0]     exec_result_s;
    flag_t            exec_flags_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             mul_last_s;
    logic             handshake_s;

    alu_exec #(.N(N)) u_exec (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .result (exec_result_s),
        .flags  (exec_flags_s)
    );

    assign in_ready_s  = (state_r == IDLE);
    assign accept_s    = in_valid & in_ready_s;
    assign mul_last_s  = (state_r == MUL) && (cnt_r == CW'(N-1));
    assign handshake_s = (state_r == DONE) & out_valid_r & out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign carry     = flags_r.carry;
    assign zero      = flags_r.zero;
    assign err       = flags_r.err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (op_t'(op) == OP_MUL) begin
                        next_state_s = MUL;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            MUL: begin
                if (mul_last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = MUL;
                end
            end
            DONE: begin
                if (handshake_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // One shift-add step: add the multiplicand when the multiplier LSB is set.
    always_comb begin
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = '0;
        end
    end

    assign acc_step_s = acc_r + addend_s;

    // Operand latch and multiply iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= OP_ADD;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (accept_s) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op_t'(op);
            mcand_r  <= {{N{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (state_r == MUL) begin
            acc_r    <= acc_step_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    // Output registers: single-cycle ops resolve on the first DONE cycle, MUL on its last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= '0;
            flags_r     <= '0;
            out_valid_r <= 1'b0;
        end else if (mul_last_s) begin
            result_r      <= acc_step_s[N-1:0];
            flags_r.carry <= |acc_step_s[2*N-1:N];
            flags_r.zero  <= (acc_step_s[N-1:0] == '0);
            flags_r.err   <= 1'b0;
            out_valid_r   <= 1'b1;
        end else if ((state_r == DONE) && !out_valid_r) begin
            result_r    <= exec_result_s;
            flags_r     <= exec_flags_s;
            out_valid_r <= 1'b1;
        end else if (handshake_s) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer (N = 4): directed commands, backpressure and mid-MUL reset.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       err;

    typedef struct {
        logic [3:0] r;
        logic       c;
        logic       z;
        logic       e;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_sequencer #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every completed output handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output result=%0d carry=%0b zero=%0b err=%0b", result, carry, zero, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (result !== e.r || carry !== e.c || zero !== e.z || err !== e.e) begin
                    failures++;
                    $display("FAIL %s got result=%0d carry=%0b zero=%0b err=%0b expected result=%0d carry=%0b zero=%0b err=%0b",
                             e.nm, result, carry, zero, err, e.r, e.c, e.z, e.e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, want);
        end
    endtask

    // Issue one command, push its expectation and check the accept-to-out_valid latency.
    task automatic issue(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] top,
                         input logic [3:0] er, input logic ec, input logic ez, input logic ee,
                         input int elat, input string nm);
        exp_t e;
        int   w;
        int   n;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check({nm, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        e.r = er; e.c = ec; e.z = ez; e.e = ee; e.nm = nm;
        exp_q.push_back(e);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n[7:0], elat[7:0]);
    endtask

    task automatic drain();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 4'd0; b = 4'd0; op = 3'd0;
        #1;
        check("reset_outputs", {2'd0, out_valid, result, carry}, 8'd0);
        check("reset_flags", {5'd0, zero, err, in_ready}, 8'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(4'd9,  4'd8,  3'b000, 4'd1,  1'b1, 1'b0, 1'b0, 1, "add_9_8");        drain();
        issue(4'd3,  4'd5,  3'b001, 4'd14, 1'b1, 1'b0, 1'b0, 1, "sub_3_5");        drain();
        issue(4'd5,  4'd5,  3'b001, 4'd0,  1'b0, 1'b1, 1'b0, 1, "sub_5_5");        drain();
        issue(4'd3,  4'd5,  3'b110, 4'd15, 1'b0, 1'b0, 1'b0, 4, "mul_3_5");        drain();
        issue(4'd6,  4'd7,  3'b110, 4'd10, 1'b1, 1'b0, 1'b0, 4, "mul_6_7");        drain();
        issue(4'd15, 4'd15, 3'b110, 4'd1,  1'b1, 1'b0, 1'b0, 4, "mul_15_15");      drain();
        issue(4'd0,  4'd9,  3'b110, 4'd0,  1'b0, 1'b1, 1'b0, 4, "mul_0_9");        drain();
        issue(4'd12, 4'd10, 3'b010, 4'd8,  1'b0, 1'b0, 1'b0, 1, "and_12_10");      drain();
        issue(4'd12, 4'd10, 3'b011, 4'd14, 1'b0, 1'b0, 1'b0, 1, "or_12_10");       drain();
        issue(4'd7,  4'd7,  3'b100, 4'd0,  1'b0, 1'b1, 1'b0, 1, "xor_7_7");        drain();
        issue(4'd11, 4'd2,  3'b101, 4'd12, 1'b1, 1'b0, 1'b0, 1, "shl_1011_2");     drain();
        issue(4'd1,  4'd6,  3'b101, 4'd4,  1'b0, 1'b0, 1'b0, 1, "shl_amt_mask");   drain();
        issue(4'd5,  4'd3,  3'b111, 4'd0,  1'b0, 1'b1, 1'b1, 1, "rsvd");           drain();
        issue(4'd15, 4'd1,  3'b000, 4'd0,  1'b1, 1'b1, 1'b0, 1, "add_wrap");       drain();

        // Backpressure: result held, new command ignored while DONE.
        out_ready = 1'b0;
        issue(4'd2, 4'd3, 3'b000, 4'd5, 1'b0, 1'b0, 1'b0, 1, "add_bp");
        a = 4'd15; b = 4'd15; op = 3'b000; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {out_valid, in_ready, result, carry, zero}, {1'b1, 1'b0, 4'd5, 1'b0, 1'b0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {6'd0, out_valid, in_ready}, 8'd1);

        // Reset in the middle of a multiply.
        issue(4'd6, 4'd7, 3'b110, 4'd10, 1'b1, 1'b0, 1'b0, 4, "mul_pre_reset"); drain();
        a = 4'd3; b = 4'd5; op = 3'b110; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mul_busy", {7'd0, in_ready}, 8'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("reset_mid_mul", {1'b0, out_valid, result, carry, zero}, 8'd0);
        check("reset_mid_mul_err", {6'd0, err, in_ready}, 8'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("ready_after_reset", {7'd0, in_ready}, 8'd1);
        issue(4'd1, 4'd1, 3'b000, 4'd2, 1'b0, 1'b0, 1'b0, 1, "add_after_reset"); drain();

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size() > 255 ? 8'd255 : 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
